pll_phase_ctrl: RTL

//  Drives the dynamic control side of the GTP_PLL_E3: pll_rst sequencing, lock supervision and the

---
 rtl/pll_ctrl_pkg.sv | 20 ++
 rtl/pll_lock_sync.sv | 24 ++
 rtl/pll_phase_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor and fine phase-step controller.
package pll_ctrl_pkg;

  localparam int NUM_OUT = 5;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_LOCK_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_FINISH
  } state_t;

  function automatic int phase_w(input int modulus);
    return $clog2(modulus);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the PLL's asynchronous LOCK into the clk domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL reset sequencing, lock supervision and paced PHASE_STEP_N pulse generation with
// per-output phase position tracking.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int PULSE_W      = 4,
  parameter int GAP_W        = 16,
  parameter int STEP_W       = 8,
  parameter int PHASE_MOD    = 40
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [2:0]                            cmd_sel,
  input  logic [STEP_W-1:0]                     cmd_steps,
  output logic                                  done,
  output logic                                  err,
  output logic                                  locked,
  input  logic                                  pll_lock,
  output logic                                  pll_rst,
  output logic [2:0]                            phase_sel,
  output logic                                  phase_dir,
  output logic                                  phase_step_n,
  output logic [NUM_OUT*phase_w(PHASE_MOD)-1:0] phase_acc
);

  localparam int PHASE_W = phase_w(PHASE_MOD);
  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [STEP_W-1:0]                remaining;
  logic [NUM_OUT-1:0][PHASE_W-1:0]  acc_q;
  logic                             lock_s;
  logic signed [STEP_W-1:0]         steps_s;

  function automatic logic [PHASE_W-1:0] wrap_step(input logic [PHASE_W-1:0] cur,
                                                   input logic up);
    if (up) return (cur == PHASE_W'(PHASE_MOD - 1)) ? '0 : cur + PHASE_W'(1);
    else    return (cur == '0) ? PHASE_W'(PHASE_MOD - 1) : cur - PHASE_W'(1);
  endfunction

  // Magnitude kept unsigned so the most negative command still yields its full count.
  function automatic logic [STEP_W-1:0] step_mag(input logic signed [STEP_W-1:0] s);
    return s[STEP_W-1] ? (~s + STEP_W'(1)) : s;
  endfunction

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  assign steps_s   = cmd_steps;
  assign phase_acc = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RST_HOLD;
      cnt          <= CNT_W'(RST_CYCLES - 1);
      pll_rst      <= 1'b1;
      phase_step_n <= 1'b1;
      phase_dir    <= 1'b0;
      phase_sel    <= '0;
      cmd_ready    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      locked       <= 1'b0;
      acc_q        <= '0;
    end else begin
      done <= 1'b0;
      // locked is high exactly in IDLE..FINISH, so this covers every post-lock state.
      if (locked && !lock_s) begin
        state        <= ST_RST_HOLD;
        cnt          <= CNT_W'(RST_CYCLES - 1);
        pll_rst      <= 1'b1;
        phase_step_n <= 1'b1;
        cmd_ready    <= 1'b0;
        locked       <= 1'b0;
        acc_q        <= '0;
        if (state != ST_IDLE) begin
          err  <= 1'b1;
          done <= 1'b1;
        end
      end else begin
        case (state)
          ST_RST_HOLD: begin
            if (cnt == '0) begin
              pll_rst <= 1'b0;
              cnt     <= CNT_W'(LOCK_TIMEOUT - 1);
              state   <= ST_LOCK_WAIT;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_LOCK_WAIT: begin
            if (lock_s) begin
              locked    <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end else if (cnt == '0) begin
              pll_rst <= 1'b1;
              cnt     <= CNT_W'(RST_CYCLES - 1);
              acc_q   <= '0;
              state   <= ST_RST_HOLD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              remaining <= step_mag(steps_s);
              if (cmd_sel > 3'd4) begin
                err   <= 1'b1;
                state <= ST_FINISH;
              end else if (steps_s == '0) begin
                err   <= 1'b0;
                state <= ST_FINISH;
              end else begin
                err       <= 1'b0;
                phase_sel <= cmd_sel;
                phase_dir <= (steps_s > 0);
                state     <= ST_SETUP;
              end
            end
          end
          ST_SETUP: begin
            phase_step_n <= 1'b0;
            cnt          <= CNT_W'(PULSE_W - 1);
            state        <= ST_PULSE;
          end
          ST_PULSE: begin
            if (cnt == '0) begin
              phase_step_n <= 1'b1;
              cnt          <= CNT_W'(GAP_W - 1);
              remaining    <= remaining - STEP_W'(1);
              for (int i = 0; i < NUM_OUT; i++) begin
                if (phase_sel == 3'(i)) acc_q[i] <= wrap_step(acc_q[i], phase_dir);
              end
              state <= ST_GAP;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == '0) begin
              if (remaining != '0) begin
                phase_step_n <= 1'b0;
                cnt          <= CNT_W'(PULSE_W - 1);
                state        <= ST_PULSE;
              end else begin
                state <= ST_FINISH;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_FINISH: begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
          default: begin
            pll_rst <= 1'b1;
            cnt     <= CNT_W'(RST_CYCLES - 1);
            state   <= ST_RST_HOLD;
          end
        endcase
      end
    end
  end

endmodule
